// File: rtl/bp_be_fe_queue_ctrl_if.sv
// FE-to-BE queue handshake bundle.
// Master is the FE/scheduler side, slave is the queue.
interface bp_be_fe_queue_ctrl_if #(
  parameter int els_p   = 8,
  parameter int width_p = 128,
  localparam int ptr_width_lp = $clog2(els_p) + 1
);
  logic [width_p-1:0]      fe_queue_i;
  logic                    fe_queue_v_i;
  logic                    fe_queue_ready_o;
  logic [width_p-1:0]      fe_queue_o;
  logic                    fe_queue_v_o;
  logic                    fe_queue_yumi_i;
  logic                    fe_queue_roll_i;
  logic                    fe_queue_deq_i;
  logic                    fe_queue_flush_i;
  logic [ptr_width_lp-1:0] occupancy_o;

  modport master (
    output fe_queue_i, fe_queue_v_i,
    output fe_queue_yumi_i, fe_queue_roll_i,
    output fe_queue_deq_i, fe_queue_flush_i,
    input  fe_queue_ready_o, fe_queue_o,
    input  fe_queue_v_o, occupancy_o
  );

  modport slave (
    input  fe_queue_i, fe_queue_v_i,
    input  fe_queue_yumi_i, fe_queue_roll_i,
    input  fe_queue_deq_i, fe_queue_flush_i,
    output fe_queue_ready_o, fe_queue_o,
    output fe_queue_v_o, occupancy_o
  );
endinterface

// File: rtl/bp_be_fe_queue_ctrl.sv
// Checkpointed FE queue: write, speculative read and commit pointers.
// Issued entries stay resident until deq, so roll can replay them.
module bp_be_fe_queue_ctrl #(
  parameter int els_p   = 8,
  parameter int width_p = 128,
  localparam int ptr_width_lp = $clog2(els_p) + 1,
  localparam int idx_w_lp     = ptr_width_lp - 1
) (
  input  logic clk_i,
  input  logic reset_i,
  bp_be_fe_queue_ctrl_if.slave q
);

  typedef logic [ptr_width_lp-1:0] ptr_t;

  localparam ptr_t els_lp = ptr_t'(els_p);

  ptr_t wptr_q, wptr_d;
  ptr_t rptr_q, rptr_d;
  ptr_t cptr_q, cptr_d;

  logic [width_p-1:0] mem_q [els_p];

  logic ready;
  logic valid;
  logic enq;
  logic do_deq;
  logic do_yumi;
  ptr_t occ;

  assign occ   = wptr_q - cptr_q;
  assign ready = ~reset_i & (occ != els_lp);
  assign valid = (rptr_q != wptr_q);

  assign q.fe_queue_ready_o = ready;
  assign q.fe_queue_v_o     = valid;
  assign q.fe_queue_o       = mem_q[rptr_q[idx_w_lp-1:0]];
  assign q.occupancy_o      = occ;

  assign enq     = q.fe_queue_v_i & ready
                 & ~q.fe_queue_flush_i;
  assign do_deq  = q.fe_queue_deq_i
                 & (cptr_q != rptr_q);
  assign do_yumi = q.fe_queue_yumi_i & valid;

  // deq resolves first so roll/flush land on the post-deq commit point
  always_comb begin
    cptr_d = cptr_q + ptr_t'(do_deq);
    wptr_d = wptr_q + ptr_t'(enq);
    rptr_d = rptr_q + ptr_t'(do_yumi);
    if (q.fe_queue_flush_i) begin
      wptr_d = cptr_d;
      rptr_d = cptr_d;
    end else if (q.fe_queue_roll_i) begin
      rptr_d = cptr_d;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cptr_q <= cptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_q[wptr_q[idx_w_lp-1:0]] <= q.fe_queue_i;
    end
  end

  deq_needs_issued: assert property (
    @(posedge clk_i) disable iff (reset_i)
    q.fe_queue_deq_i |-> (cptr_q != rptr_q)
  );

  yumi_needs_valid: assert property (
    @(posedge clk_i) disable iff (reset_i)
    q.fe_queue_yumi_i |-> valid
  );

endmodule

// File: tb/tb_bp_be_fe_queue_ctrl.sv
// Directed table-driven bench for bp_be_fe_queue_ctrl (els_p=4).
// Hand sequences cover index wrap, full at each offset, async reset.
module tb_bp_be_fe_queue_ctrl;

  localparam int EL = 4;
  localparam int W  = 16;

  logic clk;
  logic rst;

  bp_be_fe_queue_ctrl_if #(.els_p(EL), .width_p(W)) qif ();

  bp_be_fe_queue_ctrl #(.els_p(EL), .width_p(W)) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .q      (qif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         y;
    logic         r;
    logic         dq;
    logic         f;
    logic         ev;
    logic [W-1:0] ed;
    logic         er;
    logic [2:0]   eo;
  } vec_t;

  vec_t tbl[$];
  int n_cmp;
  int n_err;

  localparam logic [W-1:0] A = 16'h00A0;
  localparam logic [W-1:0] B = 16'h00B1;
  localparam logic [W-1:0] C = 16'h00C2;
  localparam logic [W-1:0] D = 16'h00D3;
  localparam logic [W-1:0] E = 16'h00E4;
  localparam logic [W-1:0] F = 16'h00F5;
  localparam logic [W-1:0] X = 16'h0000;

  function automatic vec_t mk(
    logic v, logic [W-1:0] d,
    logic y, logic r, logic dq, logic f,
    logic ev, logic [W-1:0] ed,
    logic er, logic [2:0] eo);
    vec_t t;
    t.v = v; t.d = d; t.y = y; t.r = r;
    t.dq = dq; t.f = f; t.ev = ev;
    t.ed = ed; t.er = er; t.eo = eo;
    return t;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(logic v, logic [W-1:0] d,
                       logic y, logic r, logic dq, logic f);
    qif.fe_queue_v_i     = v;
    qif.fe_queue_i       = d;
    qif.fe_queue_yumi_i  = y;
    qif.fe_queue_roll_i  = r;
    qif.fe_queue_deq_i   = dq;
    qif.fe_queue_flush_i = f;
  endtask

  task automatic step(logic v, logic [W-1:0] d,
                      logic y, logic r, logic dq, logic f);
    drive(v, d, y, r, dq, f);
    @(posedge clk);
    #1;
    drive(1'b0, X, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_state(string nm, logic ev,
                           logic [W-1:0] ed, logic er,
                           logic [2:0] eo);
    chk({nm, ".v_o"}, int'(qif.fe_queue_v_o), int'(ev));
    chk({nm, ".rdy"}, int'(qif.fe_queue_ready_o), int'(er));
    chk({nm, ".occ"}, int'(qif.occupancy_o), int'(eo));
    if (ev)
      chk({nm, ".dout"}, int'(qif.fe_queue_o), int'(ed));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    // fill / drain
    tbl.push_back(mk(1, A, 0,0,0,0, 1, A, 1, 3'd1));
    tbl.push_back(mk(1, B, 0,0,0,0, 1, A, 1, 3'd2));
    tbl.push_back(mk(1, C, 0,0,0,0, 1, A, 1, 3'd3));
    tbl.push_back(mk(1, D, 0,0,0,0, 1, A, 0, 3'd4));
    tbl.push_back(mk(1, E, 0,0,0,0, 1, A, 0, 3'd4));
    tbl.push_back(mk(0, X, 1,0,0,0, 1, B, 0, 3'd4));
    tbl.push_back(mk(0, X, 1,0,0,0, 1, C, 0, 3'd4));
    tbl.push_back(mk(0, X, 1,0,0,0, 1, D, 0, 3'd4));
    tbl.push_back(mk(0, X, 1,0,0,0, 0, X, 0, 3'd4));
    tbl.push_back(mk(0, X, 0,0,1,0, 0, X, 1, 3'd3));
    tbl.push_back(mk(0, X, 0,0,1,0, 0, X, 1, 3'd2));
    tbl.push_back(mk(0, X, 0,0,1,0, 0, X, 1, 3'd1));
    tbl.push_back(mk(0, X, 0,0,1,0, 0, X, 1, 3'd0));
    // roll replay
    tbl.push_back(mk(1, A, 0,0,0,0, 1, A, 1, 3'd1));
    tbl.push_back(mk(1, B, 0,0,0,0, 1, A, 1, 3'd2));
    tbl.push_back(mk(1, C, 0,0,0,0, 1, A, 1, 3'd3));
    tbl.push_back(mk(0, X, 1,0,0,0, 1, B, 1, 3'd3));
    tbl.push_back(mk(0, X, 1,0,0,0, 1, C, 1, 3'd3));
    tbl.push_back(mk(0, X, 0,1,0,0, 1, A, 1, 3'd3));
    tbl.push_back(mk(0, X, 1,0,0,0, 1, B, 1, 3'd3));
    tbl.push_back(mk(0, X, 1,0,0,0, 1, C, 1, 3'd3));
    tbl.push_back(mk(0, X, 1,0,0,0, 0, X, 1, 3'd3));
    // roll + deq same cycle
    tbl.push_back(mk(0, X, 0,1,1,0, 1, B, 1, 3'd2));
    tbl.push_back(mk(0, X, 1,0,0,0, 1, C, 1, 3'd2));
    tbl.push_back(mk(0, X, 1,0,0,0, 0, X, 1, 3'd2));
    tbl.push_back(mk(0, X, 0,0,1,0, 0, X, 1, 3'd1));
    tbl.push_back(mk(0, X, 0,0,1,0, 0, X, 1, 3'd0));
    // flush with deq and enq
    tbl.push_back(mk(1, A, 0,0,0,0, 1, A, 1, 3'd1));
    tbl.push_back(mk(1, B, 0,0,0,0, 1, A, 1, 3'd2));
    tbl.push_back(mk(1, C, 0,0,0,0, 1, A, 1, 3'd3));
    tbl.push_back(mk(1, D, 0,0,0,0, 1, A, 0, 3'd4));
    tbl.push_back(mk(0, X, 1,0,0,0, 1, B, 0, 3'd4));
    tbl.push_back(mk(0, X, 1,0,0,0, 1, C, 0, 3'd4));
    tbl.push_back(mk(1, E, 0,0,1,1, 0, X, 1, 3'd0));
    tbl.push_back(mk(1, E, 0,0,0,1, 0, X, 1, 3'd0));
    tbl.push_back(mk(1, F, 0,0,0,0, 1, F, 1, 3'd1));
    tbl.push_back(mk(0, X, 1,0,0,0, 0, X, 1, 3'd1));
    tbl.push_back(mk(0, X, 0,0,1,0, 0, X, 1, 3'd0));

    drive(1'b0, X, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #3;
    chk_state("reset", 1'b0, X, 1'b0, 3'd0);
    #9;
    rst = 1'b0;
    #1;
    chk("post_reset.rdy", int'(qif.fe_queue_ready_o), 1);

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].d, tbl[i].y,
           tbl[i].r, tbl[i].dq, tbl[i].f);
      chk_state($sformatf("vec%0d", i), tbl[i].ev,
                tbl[i].ed, tbl[i].er, tbl[i].eo);
    end

    // wrap-around rounds
    for (int r = 0; r < 10; r++) begin
      logic [W-1:0] dv;
      dv = W'(16'h5000 + r);
      step(1'b1, dv, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_state($sformatf("wrap%0d.enq", r),
                1'b1, dv, 1'b1, 3'd1);
      step(1'b0, X, 1'b1, 1'b0, 1'b0, 1'b0);
      chk_state($sformatf("wrap%0d.yumi", r),
                1'b0, X, 1'b1, 3'd1);
      step(1'b0, X, 1'b0, 1'b0, 1'b1, 1'b0);
      chk_state($sformatf("wrap%0d.deq", r),
                1'b0, X, 1'b1, 3'd0);
    end

    // full detection at every index offset
    for (int o = 0; o < EL; o++) begin
      for (int k = 0; k < EL; k++)
        step(1'b1, W'(16'h6000 + o * 16 + k),
             1'b0, 1'b0, 1'b0, 1'b0);
      chk_state($sformatf("full%0d", o), 1'b1,
                W'(16'h6000 + o * 16), 1'b0, 3'd4);
      step(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("full%0d.occ", o),
          int'(qif.occupancy_o), 4);
      for (int k = 0; k < EL; k++) begin
        chk($sformatf("full%0d.d%0d", o, k),
            int'(qif.fe_queue_o), 16'h6000 + o * 16 + k);
        step(1'b0, X, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      chk($sformatf("full%0d.empty", o),
          int'(qif.fe_queue_v_o), 0);
      for (int k = 0; k < EL; k++)
        step(1'b0, X, 1'b0, 1'b0, 1'b1, 1'b0);
      chk($sformatf("full%0d.drained", o),
          int'(qif.occupancy_o), 0);
      step(1'b1, 16'h7777, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, X, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, X, 1'b0, 1'b0, 1'b1, 1'b0);
    end

    // async reset mid-stream
    step(1'b1, A, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, B, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, C, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_state("pre_arst", 1'b1, A, 1'b1, 3'd3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_state("arst", 1'b0, X, 1'b0, 3'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_state("arst_rel", 1'b0, X, 1'b1, 3'd0);
    step(1'b1, E, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_state("arst_enq", 1'b1, E, 1'b1, 3'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bp_be_fe_queue_ctrl.md
Name: bp_be_fe_queue_ctrl

Overview:
- Checkpointed circular buffer that holds FE-to-BE fetch/exception packets between the front end and the BE issue scheduler.
- Three pointers:
  - write pointer: enqueue.
  - read pointer: speculative issue.
  - commit pointer: retired entries.
- Issued-but-uncommitted entries are retained. A roll rewinds issue to the oldest uncommitted entry; a deq releases one committed entry; a flush discards all uncommitted entries on a redirect.

Parameters:
- els_p, 8, number of queue entries; power of two, >=2.
- width_p, 128, packet width in bits; set to bp_fe_queue_width at instantiation.
- ptr_width_lp, log2(els_p)+1, derived; pointer width including wrap bit.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- fe_queue_i  in  width_p  packet from FE.
- fe_queue_v_i  in  1  FE packet valid.
- fe_queue_ready_o  out  1  space available; enqueue occurs when v_i & ready_o.
- fe_queue_o  out  width_p  packet at read pointer.
- fe_queue_v_o  out  1  unissued entry available.
- fe_queue_yumi_i  in  1  scheduler consumes fe_queue_o; legal only when v_o=1.
- fe_queue_roll_i  in  1  rewind read pointer to commit pointer (cache miss replay).
- fe_queue_deq_i  in  1  oldest issued entry committed; release it.
- fe_queue_flush_i  in  1  discard every uncommitted entry (redirect).
- occupancy_o  out  ptr_width_lp  entries held (write minus commit).

Behaviour:
- Reset (async assert): wptr=rptr=cptr=0, so v_o=0, ready_o=0 while reset_i=1, occupancy_o=0. Storage contents are not reset.
- ready_o = ~reset_i & (wptr - cptr != els_p). Combinational from registers; it does not depend on same-cycle deq.
- v_o = (rptr != wptr). fe_queue_o = mem[rptr[ptr_width_lp-2:0]], combinational read. No enqueue bypass: an entry written at edge t is visible from cycle t+1.
- Pointer compare uses the wrap bit. Full is equal index with differing wrap bit; empty is all bits equal. All pointer arithmetic is modulo 2^ptr_width_lp.
- Next state, per cycle:
  - enq = v_i & ready_o & ~flush_i.
  - cptr_n = cptr + (deq_i & (cptr != rptr)).
  - flush_i=1: wptr <= cptr_n, rptr <= cptr_n. Same-cycle enq and yumi are dropped.
  - else roll_i=1: rptr <= cptr_n. Same-cycle yumi is ignored. wptr <= wptr + enq.
  - else: rptr <= rptr + yumi_i, wptr <= wptr + enq.
  - cptr <= cptr_n in all cases; mem[wptr index] <= fe_queue_i when enq.
- Priority: flush > roll > yumi. deq is always applied first, so roll and deq in the same cycle rewind to the post-deq commit point.
- deq with cptr==rptr (nothing issued) is ignored; it is a simulation assertion error.
- yumi with v_o=0 is ignored; it is a simulation assertion error.
- Full boundary: enq is blocked when occupancy_o==els_p. A deq in that cycle frees space only from the next cycle.
- Simultaneous enq and yumi on an empty queue: yumi is illegal (v_o=0); the enq proceeds.
- Reset asserted mid-operation clears all pointers immediately (async). Nothing enqueued survives.

Test Plan:
- Fill/drain (els_p=4): enqueue A,B,C,D -> ready_o=0, occupancy_o=4. 5th v_i is not accepted. Yumi x4 returns A..D in order. Deq x4 -> occupancy_o=0, ready_o=1.
- Roll replay: enqueue A..C, yumi A,B, assert roll -> next cycle fe_queue_o=A, v_o=1. Yumi A,B,C are returned again. occupancy_o stays 3 until deqs.
- Roll+deq same cycle: A,B issued, deq_i=roll_i=1 -> cptr=1, rptr=1, fe_queue_o=B, occupancy_o=2.
- Flush: A,B committed-pending, C,D unissued, deq A same cycle as flush with enq E -> wptr=rptr=cptr=1. E is dropped, v_o=0, occupancy_o=0.
- Wrap-around: 10 enq/yumi/deq rounds with els_p=4 -> data order preserved across the index wrap. Full detection is correct when the wrap bits differ.
- Async reset mid-stream with 3 entries -> v_o=0 and occupancy_o=0 before the next clock edge. ready_o=1 after reset deasserts.
